rv_sram_slave: RTL and testbench
================================

Name: rv_sram_slave

Overview:
- Memory responder on the Slave side of the core's rv_if valid/ready bus, the counterpart of the fetch and LSU masters.
- Single-port word-organised SRAM model with a fixed, programmable response latency.
- Handles byte, half and word accesses with lane steering on writes, and flags misaligned or out-of-range requests.
- Used as the simulation memory and as on-chip scratch RAM behind the bus crossbar.

Parameters:
- ADDR_W, 32, address width; must match rv_if.ADDR_W.
- DATA_W, 32, data width; fixed at 32 for this block.
- DEPTH_W, 12, log2 of the number of words (4096 words = 16 KiB).
- LATENCY, 2, cycles from request accept to the ready pulse; legal range 1..15.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- s  rv_if.Slave  -  bus port; fields listed below.
- s.valid  in  1  request present; master holds it and all request fields stable until ready.
- s.ready  out  1  one-cycle completion pulse.
- s.reqtyp  in  1  0 = read, 1 = write.
- s.addr  in  ADDR_W  byte address.
- s.wdata  in  DATA_W  store data, LSB-aligned.
- s.rdata  out  DATA_W  aligned word, valid only while ready=1.
- s.cachable  in  1  ignored by this block.
- s.size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- err  out  1  one-cycle pulse, coincident with ready, for an erroneous request.

Behaviour:
- Reset: state=IDLE, ready=0, rdata=0, err=0, latency counter=0. SRAM contents are not cleared. Reset mid-transaction aborts the transaction; a pending write is not committed.
- States:
  - IDLE: on valid=1, latch reqtyp, addr, wdata and size, and decode errors. If LATENCY==1, go to RESP; otherwise load cnt=LATENCY-2 and go to WAIT.
  - WAIT: if cnt==0, go to RESP; otherwise decrement cnt.
  - RESP: ready=1 for exactly one cycle, then go to IDLE.
- Latency: valid sampled in IDLE at edge N drives ready high in the cycle following edge N+LATENCY-1. With LATENCY=1, ready is high the cycle after accept.
- Back-to-back requests: the IDLE cycle after RESP is mandatory. Maximum throughput is one request per LATENCY+1 cycles.
- Handshake: a transaction completes on valid&ready. If valid drops during WAIT (a master protocol violation), the slave still pulses ready and discards the result; no write is committed.
- Address decode:
  - off = addr - BASE_ADDR.
  - idx = off[DEPTH_W+1:2].
  - In range when off < 4*2^DEPTH_W, using unsigned compare with wrap.
- Errors, decoded at accept time:
  - size==11.
  - size==01 with addr[0]=1.
  - size==10 with addr[1:0]!=0.
  - Address out of range.
  - On error: err=1 in the RESP cycle, rdata=0, write suppressed.
- Write: committed at the RESP edge when valid&ready.
  - Byte: lane addr[1:0] <- wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} <- wdata[15:0].
  - Word: all four lanes <- wdata.
  - Untouched lanes are preserved.
- Read: rdata = mem[idx] as the full aligned word, regardless of size; the master extracts the lanes. rdata is 0 whenever ready=0.
- Writes return rdata=0.
- Request fields sampled outside IDLE are ignored.

Test Plan:
1. LATENCY=2, reset released; write word addr 0x8000_0010 wdata 0xDEADBEEF -> ready high exactly 2 cycles after accept, err=0. Then read the same address -> rdata=0xDEADBEEF in the ready cycle.
2. Lane steering:
   - Word 0x11223344 at 0x8000_0020.
   - Byte write 0xAA at 0x8000_0021 -> read returns 0x1122AA44.
   - Half write 0xBEEF at 0x8000_0022 -> read returns 0xBEEFAA44.
3. Errors:
   - Half write at 0x8000_0001 -> err=1 with ready, memory unchanged.
   - size=11 -> err=1.
   - Read at 0x8001_0000 (out of range with DEPTH_W=12) -> err=1, rdata=0.
   - Read at 0x7FFF_FFFC (below base, wraps) -> err=1.
4. LATENCY=1 with valid held high across two consecutive distinct reads -> ready pulses one cycle after each accept, separated by exactly one IDLE cycle; both rdata values correct.
5. Assert reset in WAIT during a write of 0x12345678 to 0x8000_0040 -> ready=0 and state=IDLE immediately; a subsequent read of 0x8000_0040 returns the prior contents.
6. LATENCY=4, valid dropped after the accept cycle -> ready still pulses at accept+4, and the next request is accepted normally in IDLE.

Source files
------------

// File: rtl/rv_sram_slave_if.sv
// rv_if: core valid/ready memory bus. Master holds valid and request fields
// stable until the slave pulses ready for one cycle; valid&ready completes it.
interface rv_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic              reqtyp;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              cachable;
    logic [1:0]        size;

    modport Master (output valid, reqtyp, addr, wdata, cachable, size,
                    input  ready, rdata);
    modport Slave  (input  valid, reqtyp, addr, wdata, cachable, size,
                    output ready, rdata);
endinterface

// File: rtl/rv_sram_slave.sv
// Word-organised SRAM responder on rv_if with fixed response latency, byte
// lane steering on writes and error flagging for misaligned/out-of-range access.
module rv_sram_slave #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH_W   = 12,
    parameter int                LATENCY   = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic       clock,
    input  logic       reset,
    rv_if.Slave        s,
    output logic       err,
    output logic [1:0] o_dbg_state
);
    localparam int         WORDS    = 1 << DEPTH_W;
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic                r_err;
    logic [1:0]          r_size;
    logic [1:0]          r_lane;
    logic [DEPTH_W-1:0]  r_idx;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_mem_q;
    logic [DATA_W-1:0]   mem [WORDS];

    logic [ADDR_W-1:0]   w_off;
    logic [DEPTH_W-1:0]  w_idx;
    logic [DEPTH_W-1:0]  w_rd_idx;
    logic                w_in_range;
    logic                w_req_err;
    logic                w_accept;
    logic                w_commit;
    logic [3:0]          w_be;
    logic [DATA_W-1:0]   w_wword;
    logic                w_unused;

    // Unsigned subtraction wraps addresses below the base into the high range.
    assign w_off      = s.addr - BASE_ADDR;
    assign w_idx      = w_off[DEPTH_W+1:2];
    assign w_in_range = (w_off[ADDR_W-1:DEPTH_W+2] == '0);
    assign w_req_err  = !w_in_range
                      || (s.size == 2'b11)
                      || (s.size == 2'b01 && s.addr[0])
                      || (s.size == 2'b10 && s.addr[1:0] != 2'b00);
    assign w_accept   = (r_state == ST_IDLE) && s.valid;
    assign w_commit   = (r_state == ST_RESP) && s.valid && r_we && !r_err && !reset;
    assign w_rd_idx   = (r_state == ST_IDLE) ? w_idx : r_idx;
    assign w_unused   = &{1'b0, s.cachable, w_off[1:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_size  <= 2'b00;
            r_lane  <= 2'b00;
            r_idx   <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt   <= CNT_INIT;
                r_we    <= s.reqtyp;
                r_err   <= w_req_err;
                r_size  <= s.size;
                r_lane  <= s.addr[1:0];
                r_idx   <= w_idx;
                r_wdata <= s.wdata;
            end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (s.valid) w_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (r_cnt == 4'd0) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Replicate store data across lanes; the byte enables pick the target lanes.
    always_comb begin
        w_be    = 4'b0000;
        w_wword = r_wdata;
        case (r_size)
            2'b00: begin
                w_be    = 4'b0001 << r_lane;
                w_wword = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = r_lane[1] ? 4'b1100 : 4'b0011;
                w_wword = {2{r_wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) mem[r_idx][8*b +: 8] <= w_wword[8*b +: 8];
            end
        end
        if (w_next == ST_RESP) r_mem_q <= mem[w_rd_idx];
    end

    assign s.ready     = (r_state == ST_RESP);
    assign s.rdata     = (r_state == ST_RESP && !r_we && !r_err) ? r_mem_q : '0;
    assign err         = (r_state == ST_RESP) && r_err;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_rv_sram_slave.sv
// Directed bench for rv_sram_slave: three instances with LATENCY 2, 1 and 4.
module tb_rv_sram_slave;
    logic        clk;
    logic        d_rst    [3];
    logic        d_valid  [3];
    logic        d_reqtyp [3];
    logic [31:0] d_addr   [3];
    logic [31:0] d_wdata  [3];
    logic [1:0]  d_size   [3];
    logic        w_ready  [3];
    logic [31:0] w_rdata  [3];
    logic        w_err    [3];
    logic [1:0]  w_state  [3];

    int checks = 0;
    int errors = 0;

    rv_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    rv_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    rv_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

    assign bus0.valid = d_valid[0];  assign bus0.reqtyp = d_reqtyp[0];
    assign bus0.addr  = d_addr[0];   assign bus0.wdata  = d_wdata[0];
    assign bus0.size  = d_size[0];   assign bus0.cachable = 1'b0;
    assign w_ready[0] = bus0.ready;  assign w_rdata[0] = bus0.rdata;
    assign bus1.valid = d_valid[1];  assign bus1.reqtyp = d_reqtyp[1];
    assign bus1.addr  = d_addr[1];   assign bus1.wdata  = d_wdata[1];
    assign bus1.size  = d_size[1];   assign bus1.cachable = 1'b1;
    assign w_ready[1] = bus1.ready;  assign w_rdata[1] = bus1.rdata;
    assign bus2.valid = d_valid[2];  assign bus2.reqtyp = d_reqtyp[2];
    assign bus2.addr  = d_addr[2];   assign bus2.wdata  = d_wdata[2];
    assign bus2.size  = d_size[2];   assign bus2.cachable = 1'b0;
    assign w_ready[2] = bus2.ready;  assign w_rdata[2] = bus2.rdata;

    rv_sram_slave #(.LATENCY(2)) u_lat2 (.clock(clk), .reset(d_rst[0]), .s(bus0.Slave),
                                         .err(w_err[0]), .o_dbg_state(w_state[0]));
    rv_sram_slave #(.LATENCY(1)) u_lat1 (.clock(clk), .reset(d_rst[1]), .s(bus1.Slave),
                                         .err(w_err[1]), .o_dbg_state(w_state[1]));
    rv_sram_slave #(.LATENCY(4)) u_lat4 (.clock(clk), .reset(d_rst[2]), .s(bus2.Slave),
                                         .err(w_err[2]), .o_dbg_state(w_state[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] sz);
        d_valid[k]  = 1'b1;
        d_reqtyp[k] = we;
        d_addr[k]   = addr;
        d_wdata[k]  = wdata;
        d_size[k]   = sz;
    endtask

    // Counts negedges after the accept edge until ready is seen (bounded).
    task automatic wait_ready(input int k, output int lat);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (w_ready[k]) break;
        end
    endtask

    task automatic txn(input int k, input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] sz, input int exp_lat,
                       input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        @(negedge clk);
        drive(k, we, addr, wdata, sz);
        @(posedge clk);
        wait_ready(k, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, w_rdata[k], exp_rdata);
        chk({tag, "_err"}, {31'd0, w_err[k]}, {31'd0, exp_err});
        @(posedge clk);
        #1 d_valid[k] = 1'b0;
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, w_ready[k]}, 32'd0);
    endtask

    initial begin
        int lat;
        for (int k = 0; k < 3; k++) begin
            d_rst[k] = 1'b1; d_valid[k] = 1'b0; d_reqtyp[k] = 1'b0;
            d_addr[k] = 32'd0; d_wdata[k] = 32'd0; d_size[k] = 2'b00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) d_rst[k] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rst_state", {30'd0, w_state[k]}, 32'd0);
            chk("rst_ready", {31'd0, w_ready[k]}, 32'd0);
            chk("rst_rdata", w_rdata[k], 32'd0);
            chk("rst_err", {31'd0, w_err[k]}, 32'd0);
        end

        // Basic word write/read, LATENCY=2
        txn(0, "wr_word", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 2'b10, 2, 32'd0, 1'b0);
        txn(0, "rd_word", 1'b0, 32'h8000_0010, 32'd0,        2'b10, 2, 32'hDEAD_BEEF, 1'b0);

        // Lane steering; junk in unused upper wdata bits must not leak
        txn(0, "wr_base", 1'b1, 32'h8000_0020, 32'h1122_3344, 2'b10, 2, 32'd0, 1'b0);
        txn(0, "wr_byte", 1'b1, 32'h8000_0021, 32'hFFFF_FFAA, 2'b00, 2, 32'd0, 1'b0);
        txn(0, "rd_byte", 1'b0, 32'h8000_0020, 32'd0,         2'b10, 2, 32'h1122_AA44, 1'b0);
        txn(0, "wr_half", 1'b1, 32'h8000_0022, 32'h5555_BEEF, 2'b01, 2, 32'd0, 1'b0);
        txn(0, "rd_half", 1'b0, 32'h8000_0020, 32'd0,         2'b10, 2, 32'hBEEF_AA44, 1'b0);
        txn(0, "rd_bsz",  1'b0, 32'h8000_0023, 32'd0,         2'b00, 2, 32'hBEEF_AA44, 1'b0);

        // Errors
        txn(0, "wr_w0",   1'b1, 32'h8000_0000, 32'h0102_0304, 2'b10, 2, 32'd0, 1'b0);
        txn(0, "e_half",  1'b1, 32'h8000_0001, 32'h0000_CAFE, 2'b01, 2, 32'd0, 1'b1);
        txn(0, "rd_w0",   1'b0, 32'h8000_0000, 32'd0,         2'b10, 2, 32'h0102_0304, 1'b0);
        txn(0, "e_size",  1'b1, 32'h8000_0010, 32'h0000_0000, 2'b11, 2, 32'd0, 1'b1);
        txn(0, "rd_keep", 1'b0, 32'h8000_0010, 32'd0,         2'b10, 2, 32'hDEAD_BEEF, 1'b0);
        txn(0, "e_range", 1'b0, 32'h8001_0000, 32'd0,         2'b10, 2, 32'd0, 1'b1);
        txn(0, "e_below", 1'b0, 32'h7FFF_FFFC, 32'd0,         2'b10, 2, 32'd0, 1'b1);
        txn(0, "e_walgn", 1'b0, 32'h8000_0012, 32'd0,         2'b10, 2, 32'd0, 1'b1);
        txn(0, "wr_last", 1'b1, 32'h8000_3FFC, 32'hCAFE_F00D, 2'b10, 2, 32'd0, 1'b0);
        txn(0, "rd_last", 1'b0, 32'h8000_3FFC, 32'd0,         2'b10, 2, 32'hCAFE_F00D, 1'b0);
        txn(0, "e_end",   1'b0, 32'h8000_4000, 32'd0,         2'b10, 2, 32'd0, 1'b1);

        // LATENCY=1, valid held high across two reads
        txn(1, "l1_wa", 1'b1, 32'h8000_0100, 32'hA5A5_0001, 2'b10, 1, 32'd0, 1'b0);
        txn(1, "l1_wb", 1'b1, 32'h8000_0104, 32'h5A5A_0002, 2'b10, 1, 32'd0, 1'b0);
        @(negedge clk);
        drive(1, 1'b0, 32'h8000_0100, 32'd0, 2'b10);
        @(posedge clk);
        @(negedge clk);
        chk("l1_rdy_a", {31'd0, w_ready[1]}, 32'd1);
        chk("l1_rd_a", w_rdata[1], 32'hA5A5_0001);
        d_addr[1] = 32'h8000_0104;
        @(negedge clk);
        chk("l1_gap_rdy", {31'd0, w_ready[1]}, 32'd0);
        chk("l1_gap_st", {30'd0, w_state[1]}, 32'd0);
        @(negedge clk);
        chk("l1_rdy_b", {31'd0, w_ready[1]}, 32'd1);
        chk("l1_rd_b", w_rdata[1], 32'h5A5A_0002);
        @(posedge clk);
        #1 d_valid[1] = 1'b0;
        @(negedge clk);
        chk("l1_end_rdy", {31'd0, w_ready[1]}, 32'd0);

        // Reset during WAIT aborts a pending write
        txn(0, "rs_pre", 1'b1, 32'h8000_0040, 32'h0BAD_F00D, 2'b10, 2, 32'd0, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 32'h8000_0040, 32'h1234_5678, 2'b10);
        @(posedge clk);
        #1 chk("rs_wait", {30'd0, w_state[0]}, 32'd1);
        d_rst[0] = 1'b1;
        #1;
        chk("rs_rdy", {31'd0, w_ready[0]}, 32'd0);
        chk("rs_st", {30'd0, w_state[0]}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        d_valid[0] = 1'b0;
        d_rst[0]   = 1'b0;
        txn(0, "rs_rd", 1'b0, 32'h8000_0040, 32'd0, 2'b10, 2, 32'h0BAD_F00D, 1'b0);

        // LATENCY=4, valid dropped after accept
        txn(2, "l4_pre", 1'b1, 32'h8000_0200, 32'h3333_3333, 2'b10, 4, 32'd0, 1'b0);
        @(negedge clk);
        drive(2, 1'b1, 32'h8000_0200, 32'h7777_7777, 2'b10);
        @(posedge clk);
        #1 d_valid[2] = 1'b0;
        wait_ready(2, lat);
        chk("l4_drop_lat", 32'(lat), 32'd4);
        chk("l4_drop_err", {31'd0, w_err[2]}, 32'd0);
        @(posedge clk);
        #1;
        chk("l4_drop_pulse", {31'd0, w_ready[2]}, 32'd0);
        chk("l4_drop_st", {30'd0, w_state[2]}, 32'd0);
        txn(2, "l4_rd", 1'b0, 32'h8000_0200, 32'd0, 2'b10, 4, 32'h3333_3333, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
